// File: rtl/serial_pkg.sv
// Shared serial-link constants and types, used by both the transmit and receive paths
// so that bit timing and frame shape always agree.
package serial_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;
  localparam int DEF_STOP_BITS    = 1;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Counter width for a modulo-n count; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle
// of each bit.
module tx_bit_timer import serial_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic bitEnd
);

  localparam int              CNT_W = cnt_w(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign bitEnd = en && (cnt_q == LAST);

endmodule

// File: rtl/serial_transmit.sv
// Serial transmitter: start bit, LSB-first data, stop bit(s), with a one-entry holding
// register so a queued byte follows the current frame without an idle gap.
module serial_transmit import serial_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int STOP_BITS    = DEF_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] parallelDataIn,
  input  logic                 load,
  output logic                 ready,
  output logic                 serialDataOut,
  output logic                 busy,
  output logic                 charSent
);

  localparam int               IDX_W    = cnt_w(DATA_BITS);
  localparam int               STP_W    = $clog2(STOP_BITS + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [STP_W-1:0] STP_LAST = STP_W'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [STP_W-1:0]     stp_q, stp_d;
  logic                 line_q, line_d;

  logic                 bit_end, accept, avail, frame_done;
  logic [DATA_BITS-1:0] next_byte;

  tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q != IDLE),
    .clr    (state_q == IDLE),
    .bitEnd (bit_end)
  );

  assign accept     = load && !hold_full_q;
  // A held byte always goes before a new one; the two are never both live.
  assign avail      = hold_full_q || accept;
  assign next_byte  = hold_full_q ? hold_q : parallelDataIn;
  assign frame_done = (state_q == STOP) && bit_end && (stp_q == STP_LAST);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    idx_d       = idx_q;
    stp_d       = stp_q;

    case (state_q)
      IDLE: if (avail) begin
        state_d     = START;
        shift_d     = next_byte;
        hold_full_d = 1'b0;
      end
      START: if (bit_end) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        if (idx_q == IDX_LAST) begin
          state_d = STOP;
          stp_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      STOP: if (bit_end) begin
        if (stp_q != STP_LAST) begin
          stp_d = stp_q + STP_W'(1);
        end else if (avail) begin
          state_d     = START;
          shift_d     = next_byte;
          hold_full_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Mid-frame accepts park in the holding register; at frame end they bypass it.
    if (state_q != IDLE && accept && !frame_done) begin
      hold_d      = parallelDataIn;
      hold_full_d = 1'b1;
    end

    case (state_d)
      START:   line_d = START_LEVEL;
      DATA:    line_d = shift_d[0];
      default: line_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      idx_q       <= '0;
      stp_q       <= '0;
      line_q      <= LINE_IDLE;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      idx_q       <= idx_d;
      stp_q       <= stp_d;
      line_q      <= line_d;
    end
  end

  assign serialDataOut = line_q;
  assign busy          = (state_q != IDLE);
  assign ready         = !hold_full_q;
  assign charSent      = frame_done;

endmodule
